uart_rx_loader: RTL and testbench

- Serial front end that feeds the CPU datapath's UART load port.
- Receives 8N1 UART bytes and decodes a load-frame protocol (header, word count, 16-bit words).
- Emits one-cycle uart_en pulses with uart_sel/uart_data, which the datapath uses to fill instruction memory (sel=2) or data memory (sel=1).
- Sits between the board RX pin and the datapath.

---
 rtl/uart_rx_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// UART 8N1 receiver plus load-frame decoder that drives the datapath's UART load port.
// A frame is a header byte, a word count, then 16-bit words sent high byte first.
module uart_rx_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HDR_MEM      = 8'hA1,
    parameter logic [7:0]  HDR_INST     = 8'hA2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        uart_en,
    output logic [1:0]  uart_sel,
    output logic [15:0] uart_data,
    output logic        load_busy,
    output logic        load_done,
    output logic        frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        F_HDR,
        F_CNT,
        F_HI,
        F_LO
    } f_state_e;

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             err_wait_q, err_wait_d;
    logic             byte_valid_q, byte_valid_d;
    logic             byte_err_q, byte_err_d;

    f_state_e         f_state_q, f_state_d;
    logic [8:0]       remain_q, remain_d;
    logic [7:0]       hi_q, hi_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      data_q, data_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    // Two-flop synchronizer; presets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            err_wait_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            err_wait_q   <= err_wait_d;
            byte_valid_q <= byte_valid_d;
            byte_err_q   <= byte_err_d;
        end
    end

    // Bit-level receiver; after a bad stop bit, the line must return high before a new start.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        err_wait_d   = err_wait_q;
        byte_valid_d = 1'b0;
        byte_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (rx_sync_q) begin
                    err_wait_d = 1'b0;
                end else if (!err_wait_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        byte_err_d = 1'b1;
                        err_wait_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_state_q <= F_HDR;
            remain_q  <= '0;
            hi_q      <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            f_state_q <= f_state_d;
            remain_q  <= remain_d;
            hi_q      <= hi_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    // Frame decoder; busy/sel linger one cycle past load_done but drop with frame_err.
    always_comb begin
        f_state_d = f_state_q;
        remain_d  = remain_q;
        hi_d      = hi_q;
        sel_d     = sel_q;
        data_d    = data_q;
        en_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        if (done_q) begin
            busy_d = 1'b0;
            sel_d  = 2'd0;
        end
        if (byte_err_q && (f_state_q != F_HDR)) begin
            ferr_d    = 1'b1;
            busy_d    = 1'b0;
            sel_d     = 2'd0;
            f_state_d = F_HDR;
        end else if (byte_valid_q) begin
            case (f_state_q)
                F_HDR: begin
                    if (shift_q == HDR_MEM) begin
                        sel_d     = 2'd1;
                        busy_d    = 1'b1;
                        f_state_d = F_CNT;
                    end else if (shift_q == HDR_INST) begin
                        sel_d     = 2'd2;
                        busy_d    = 1'b1;
                        f_state_d = F_CNT;
                    end
                end
                F_CNT: begin
                    remain_d  = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                    f_state_d = F_HI;
                end
                F_HI: begin
                    hi_d      = shift_q;
                    f_state_d = F_LO;
                end
                F_LO: begin
                    data_d = {hi_q, shift_q};
                    en_d   = 1'b1;
                    if (remain_q != 9'd0) begin
                        remain_d = remain_q - 9'd1;
                    end
                    if (remain_q > 9'd1) begin
                        f_state_d = F_HI;
                    end else begin
                        f_state_d = F_HDR;
                        done_d    = 1'b1;
                    end
                end
                default: f_state_d = F_HDR;
            endcase
        end
    end

    assign uart_en   = en_q;
    assign uart_sel  = sel_q;
    assign uart_data = data_q;
    assign load_busy = busy_q;
    assign load_done = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Randomized bench for uart_rx_loader: byte streams are serialized onto rx and the
// decoded words are compared against a stream-level parse of the same bytes.
module tb_uart_rx_loader;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        uart_en;
    logic [1:0]  uart_sel;
    logic [15:0] uart_data;
    logic        load_busy;
    logic        load_done;
    logic        frame_err;

    uart_rx_loader #(
        .CLKS_PER_BIT(CPB),
        .HDR_MEM     (8'hA1),
        .HDR_INST    (8'hA2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .uart_en  (uart_en),
        .uart_sel (uart_sel),
        .uart_data(uart_data),
        .load_busy(load_busy),
        .load_done(load_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus stream: byte value plus whether its stop bit is good
    logic [7:0]  st_b[$];
    bit          st_ok[$];
    logic [17:0] exp_q[$];
    int          exp_done, exp_ferr;
    bit          exp_open;

    // Observed activity
    logic [17:0] obs_q[$];
    int          obs_done = 0, obs_ferr = 0, inv_viol = 0;
    logic        done_prev = 1'b0, ferr_prev = 1'b0, en_prev = 1'b0, busy_prev = 1'b0;
    logic [1:0]  sel_prev = 2'd0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            done_prev = 1'b0; ferr_prev = 1'b0; en_prev = 1'b0; busy_prev = 1'b0; sel_prev = 2'd0;
        end else begin
            if (uart_en) obs_q.push_back({uart_sel, uart_data});
            if (uart_en && (uart_sel == 2'd0 || en_prev)) inv_viol++;
            if (load_done) begin
                obs_done++;
                if (!uart_en || !load_busy) inv_viol++;
            end
            if (done_prev && (load_busy || uart_sel != 2'd0)) inv_viol++;
            if (frame_err) begin
                obs_ferr++;
                if (load_busy || uart_sel != 2'd0 || uart_en || ferr_prev) inv_viol++;
            end
            if (!load_busy && uart_sel != 2'd0) inv_viol++;
            if (busy_prev && load_busy && uart_sel != sel_prev) inv_viol++;
            done_prev = load_done; ferr_prev = frame_err; en_prev = uart_en;
            busy_prev = load_busy; sel_prev = uart_sel;
        end
    end

    // Reference: parse the byte stream directly by the protocol rules
    task automatic run_model();
        int i, n, got;
        logic [1:0] sel;
        logic [7:0] hi;
        bit aborted;
        exp_q.delete();
        exp_done = 0;
        exp_ferr = 0;
        exp_open = 1'b0;
        i = 0;
        while (i < st_b.size()) begin
            i++;
            if (!st_ok[i-1] || (st_b[i-1] != 8'hA1 && st_b[i-1] != 8'hA2)) continue;
            sel = (st_b[i-1] == 8'hA1) ? 2'd1 : 2'd2;
            if (i >= st_b.size()) begin exp_open = 1'b1; break; end
            if (!st_ok[i]) begin exp_ferr++; i++; continue; end
            n = (st_b[i] == 8'd0) ? 256 : int'(st_b[i]);
            i++;
            got = 0;
            aborted = 1'b0;
            while (got < n) begin
                if (i >= st_b.size()) begin exp_open = 1'b1; break; end
                if (!st_ok[i]) begin exp_ferr++; i++; aborted = 1'b1; break; end
                hi = st_b[i];
                i++;
                if (i >= st_b.size()) begin exp_open = 1'b1; break; end
                if (!st_ok[i]) begin exp_ferr++; i++; aborted = 1'b1; break; end
                exp_q.push_back({sel, hi, st_b[i]});
                i++;
                got++;
            end
            if (got == n) exp_done++;
            if (exp_open) break;
            if (aborted) continue;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB / 2 + 4) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (4) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b, input bit ok);
        st_b.push_back(b);
        st_ok.push_back(ok);
    endtask

    task automatic run_scenario(input string name);
        int m;
        run_model();
        for (int i = 0; i < st_b.size(); i++) send_byte(st_b[i], st_ok[i]);
        repeat (24) @(negedge clk);
        check_eq({name, "_nwords"}, 32'(obs_q.size()), 32'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            if (obs_q[i] !== exp_q[i] || i < 4 || i == m - 1)
                check_eq($sformatf("%s_w%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        check_eq({name, "_done"}, 32'(obs_done), 32'(exp_done));
        check_eq({name, "_ferr"}, 32'(obs_ferr), 32'(exp_ferr));
        check_eq({name, "_inv"}, 32'(inv_viol), 32'd0);
        obs_q.delete();
        obs_done = 0; obs_ferr = 0; inv_viol = 0;
        st_b.delete();
        st_ok.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        obs_done = 0; obs_ferr = 0; inv_viol = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr, jb;
        int n, nbytes, errpos;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {26'd0, uart_en, uart_sel, load_busy, load_done, frame_err}, 32'd0);
        check_eq("rst_data", 32'(uart_data), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Instruction load of two words
        push(8'hA2, 1); push(8'h02, 1); push(8'h12, 1); push(8'h34, 1); push(8'hAB, 1); push(8'hCD, 1);
        run_scenario("inst2");
        check_eq("inst2_busy_after", 32'(load_busy), 32'd0);

        // Junk byte then one data-memory word
        push(8'h55, 1); push(8'hA1, 1); push(8'h01, 1); push(8'h00, 1); push(8'h07, 1);
        run_scenario("junk_mem1");

        // Stop-bit error inside a frame, then recovery
        push(8'hA2, 1); push(8'h01, 1); push(8'h12, 1); push(8'h34, 0);
        push(8'hA1, 1); push(8'h01, 1); push(8'hFF, 1); push(8'hFF, 1);
        run_scenario("stoperr");

        // Errored byte while waiting for a header is ignored
        push(8'hA1, 0); push(8'hA2, 1); push(8'h01, 1); push(8'h9C, 1); push(8'h3E, 1);
        run_scenario("hdr_err");

        // Short low glitch on an idle line
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_busy", 32'(load_busy), 32'd0);
        push(8'hA1, 1); push(8'h01, 1); push(8'hBE, 1); push(8'hEF, 1);
        run_scenario("glitch");

        // Reset while the frame waits for its low byte
        push(8'hA2, 1); push(8'h01, 1); push(8'h12, 1);
        run_scenario("pre_reset");
        check_eq("pre_reset_busy", {30'd0, load_busy, 1'b0} | 32'(uart_sel) << 4, 32'h22);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("async_rst_outs", {26'd0, uart_en, uart_sel, load_busy, load_done, frame_err}, 32'd0);
        check_eq("async_rst_data", 32'(uart_data), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        obs_q.delete(); obs_done = 0; obs_ferr = 0; inv_viol = 0;
        push(8'hA2, 1); push(8'h01, 1); push(8'h56, 1); push(8'h78, 1);
        run_scenario("post_reset");

        // Randomized frames with occasional junk and stop-bit errors
        for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA1 || jb == 8'hA2) jb = jb ^ 8'h10;
                push(jb, 1);
            end
            hdr = ($urandom_range(0, 1) == 1) ? 8'hA1 : 8'hA2;
            n = $urandom_range(1, 3);
            nbytes = 2 + 2 * n;
            errpos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nbytes - 1) : -1;
            for (int k = 0; k < nbytes; k++) begin
                if (k == 0)      push(hdr, errpos != 0);
                else if (k == 1) push(8'(n), errpos != 1);
                else             push(8'($urandom_range(0, 255)), errpos != k);
            end
            run_scenario($sformatf("rnd%0d", f));
            if (exp_open) do_reset();
        end

        // Count byte 0 means 256 words; following bytes parse as headers again
        push(8'hA1, 1); push(8'h00, 1);
        for (int k = 0; k < 512; k++) push(8'($urandom_range(0, 255)), 1);
        push(8'h55, 1); push(8'hA2, 1); push(8'h01, 1); push(8'h12, 1); push(8'h34, 1);
        run_scenario("cnt256");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
